collision_query_arbiter: RTL and testbench

- Shares one collision_mask lookup port among NUM_REQ requesters, e.g. player pawns or the AI mover, that each want to test a target pixel coordinate for walkability.
- Round-robin arbitration, valid/ready request handshake, fixed-latency lookup sequencing, one-hot response pulse.
- Sits between the per-player movement logic and the single collision_mask instance, which it drives through cm_x/cm_y and reads back on cm_walkable.

---
 rtl/collision_query_arbiter.sv | 139 +++++++++++++
 tb/tb_collision_query_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_query_arbiter.sv
// rtl/collision_query_arbiter.sv - round-robin arbiter sharing one collision_mask lookup port
// Optional feature macro: COLLISION_ARB_STATS_EN (lookup / blocked counters with stat_clr)
module collision_query_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int X_W        = 11,
   parameter int Y_W        = 10,
   parameter int SCREEN_W   = 1280,
   parameter int SCREEN_H   = 800,
   parameter int LOOKUP_LAT = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ*X_W-1:0] req_x,
   input  logic [NUM_REQ*Y_W-1:0] req_y,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [NUM_REQ-1:0]     rsp_valid,
   output logic                   rsp_walkable,
   output logic                   busy,
   output logic [X_W-1:0]         cm_x,
   output logic [Y_W-1:0]         cm_y,
   input  logic                   cm_walkable
`ifdef COLLISION_ARB_STATS_EN
   ,
   input  logic                   stat_clr,
   output logic [15:0]            stat_lookups,
   output logic [15:0]            stat_blocked
`endif
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

   state_t           state;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] grant_idx;
   logic [2:0]       cnt;

   int               idx;
   logic [IDX_W-1:0] cand;
   logic [IDX_W-1:0] sel_idx;
   logic             sel_hit;
   logic [X_W-1:0]   sel_x;
   logic [Y_W-1:0]   sel_y;
   logic             sel_oob;

   // Search upward from rr_ptr with wrap; the first valid requester wins.
   always_comb begin
      idx     = 0;
      cand    = '0;
      sel_hit = 1'b0;
      sel_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         cand = IDX_W'(idx);
         if (!sel_hit && req_valid[cand]) begin
            sel_hit = 1'b1;
            sel_idx = cand;
         end
      end
      sel_x   = req_x[sel_idx*X_W +: X_W];
      sel_y   = req_y[sel_idx*Y_W +: Y_W];
      sel_oob = ({1'b0, sel_x} >= (X_W+1)'(SCREEN_W)) ||
                ({1'b0, sel_y} >= (Y_W+1)'(SCREEN_H));
      req_ready = '0;
      if (rst_n && state == IDLE && sel_hit) req_ready[sel_idx] = 1'b1;
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         grant_idx    <= '0;
         cnt          <= '0;
         cm_x         <= '0;
         cm_y         <= '0;
         rsp_valid    <= '0;
         rsp_walkable <= 1'b0;
      end else begin
         rsp_valid <= '0;
         case (state)
            IDLE: begin
               if (sel_hit) begin
                  cm_x      <= sel_x;
                  cm_y      <= sel_y;
                  grant_idx <= sel_idx;
                  rr_ptr    <= (sel_idx == IDX_W'(NUM_REQ-1)) ? '0 : sel_idx + 1'b1;
                  // Off-screen targets are never walkable; skip the lookup entirely.
                  if (sel_oob) begin
                     rsp_walkable <= 1'b0;
                     rsp_valid    <= NUM_REQ'(1) << sel_idx;
                     state        <= RESP;
                  end else begin
                     cnt   <= 3'(LOOKUP_LAT);
                     state <= LOOKUP;
                  end
               end
            end
            LOOKUP: begin
               if (cnt != 3'd0) begin
                  cnt <= cnt - 3'd1;
               end else begin
                  rsp_walkable <= cm_walkable;
                  rsp_valid    <= NUM_REQ'(1) << grant_idx;
                  state        <= RESP;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef COLLISION_ARB_STATS_EN
   logic was_lookup;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         was_lookup   <= 1'b0;
         stat_lookups <= '0;
         stat_blocked <= '0;
      end else begin
         if (state == IDLE && sel_hit) was_lookup <= !sel_oob;
         if (stat_clr) begin
            stat_lookups <= '0;
            stat_blocked <= '0;
         end else if (state == RESP) begin
            if (was_lookup && stat_lookups != 16'hFFFF) stat_lookups <= stat_lookups + 16'd1;
            if (!rsp_walkable && stat_blocked != 16'hFFFF) stat_blocked <= stat_blocked + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_collision_query_arbiter.sv
// tb/tb_collision_query_arbiter.sv - directed self-checking bench for collision_query_arbiter
module tb_collision_query_arbiter;

   localparam int NR  = 4;
   localparam int X_W = 11;
   localparam int Y_W = 10;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NR-1:0]     req_valid;
   logic [NR*X_W-1:0] req_x;
   logic [NR*Y_W-1:0] req_y;
   logic [NR-1:0]     req_ready;
   logic [NR-1:0]     rsp_valid;
   logic              rsp_walkable;
   logic              busy;
   logic [X_W-1:0]    cm_x;
   logic [Y_W-1:0]    cm_y;
   logic              cm_walkable;
`ifdef COLLISION_ARB_STATS_EN
   logic              stat_clr;
   logic [15:0]       stat_lookups;
   logic [15:0]       stat_blocked;
`endif

   int checks   = 0;
   int failures = 0;

   collision_query_arbiter #(.NUM_REQ(NR), .X_W(X_W), .Y_W(Y_W), .LOOKUP_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_walkable(rsp_walkable),
      .busy(busy), .cm_x(cm_x), .cm_y(cm_y), .cm_walkable(cm_walkable)
`ifdef COLLISION_ARB_STATS_EN
      , .stat_clr(stat_clr), .stat_lookups(stat_lookups), .stat_blocked(stat_blocked)
`endif
   );

   always #5 clk = ~clk;

   // One-cycle collision_mask stand-in: only tile (row 6, col 15) is a wall.
   always_ff @(posedge clk)
      cm_walkable <= !((int'(cm_x) / 32 == 15) && (int'(cm_y) / 32 == 6));

   task automatic issue(input int i, input int x, input int y, output logic [NR-1:0] seen, output int ok);
      req_valid[i] = 1'b1;
      req_x[i*X_W +: X_W] = X_W'(x);
      req_y[i*Y_W +: Y_W] = Y_W'(y);
      ok = 0;
      seen = '0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (req_ready != '0) begin
            seen = req_ready;
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      req_valid[i] = 1'b0;
   endtask

   task automatic wait_rsp(output int lat, output logic [NR-1:0] v, output logic w);
      lat = -1;
      v = '0;
      w = 1'bx;
      for (int k = 1; k <= 10; k++) begin
         if (rsp_valid != '0) begin
            lat = k;
            v = rsp_valid;
            w = rsp_walkable;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      req_valid = 4'b0101;
      req_x = '0;
      req_y = '0;
      repeat (2) @(negedge clk);
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
      checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
      checks++; if ({busy, rsp_walkable} !== 2'b00) begin failures++; $display("FAIL reset_busy_walk got=%b exp=00", {busy, rsp_walkable}); end
      checks++; if ({cm_x, cm_y} !== '0) begin failures++; $display("FAIL reset_cm got=%0d,%0d exp=0,0", cm_x, cm_y); end
      req_valid = '0;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_lookup(input int x, input int y, input logic exp_w, input string nm);
      logic [NR-1:0] seen, v;
      int ok, lat;
      logic w;
      issue(0, x, y, seen, ok);
      checks++; if (seen !== 4'b0001) begin failures++; $display("FAIL %s_grant got=%b exp=0001", nm, seen); end
      checks++; if ({busy, cm_x, cm_y} !== {1'b1, X_W'(x), Y_W'(y)}) begin
         failures++; $display("FAIL %s_cm got=%0d,%0d,%0d exp=1,%0d,%0d", nm, busy, cm_x, cm_y, x, y); end
      wait_rsp(lat, v, w);
      checks++; if (lat !== 3) begin failures++; $display("FAIL %s_latency got=%0d exp=3", nm, lat); end
      checks++; if (v !== 4'b0001) begin failures++; $display("FAIL %s_rsp_valid got=%b exp=0001", nm, v); end
      checks++; if (w !== exp_w) begin failures++; $display("FAIL %s_walkable got=%b exp=%b", nm, w, exp_w); end
      @(negedge clk);
      checks++; if ({rsp_valid, busy, rsp_walkable} !== {4'b0000, 1'b0, exp_w}) begin
         failures++; $display("FAIL %s_after got=%b,%b,%b exp=0000,0,%b", nm, rsp_valid, busy, rsp_walkable, exp_w); end
   endtask

   task automatic test_round_robin;
      logic [NR-1:0] exp_g [4] = '{4'b0001, 4'b0100, 4'b1000, 4'b0001};
      logic [NR-1:0] rdy, v;
      int wcnt, lat;
      logic w;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      req_x = {X_W'(300), X_W'(200), X_W'(100), X_W'(64)};
      req_y = {Y_W'(300), Y_W'(200), Y_W'(100), Y_W'(64)};
      req_valid = 4'b1101;
      for (int g = 0; g < 4; g++) begin
         if (g > 0) @(negedge clk);
         wcnt = 0;
         rdy = '0;
         while (wcnt < 10) begin
            #1;
            if (req_ready != '0) begin rdy = req_ready; break; end
            @(negedge clk);
            wcnt++;
         end
         checks++; if (rdy !== exp_g[g]) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", g, rdy, exp_g[g]); end
         checks++; if (wcnt !== 0) begin failures++; $display("FAIL rr_gap%0d got=%0d exp=0", g, wcnt); end
         @(negedge clk);
         wait_rsp(lat, v, w);
         checks++; if ({lat, v} !== {32'sd3, exp_g[g]}) begin
            failures++; $display("FAIL rr_rsp%0d got=%0d,%b exp=3,%b", g, lat, v, exp_g[g]); end
      end
      req_valid = '0;
      @(negedge clk);
   endtask

   task automatic test_out_of_bounds;
      int xs [2] = '{1280, 10};
      int ys [2] = '{10, 800};
      logic [NR-1:0] seen, v;
      int ok, lat;
      logic w;
      for (int t = 0; t < 2; t++) begin
         issue(1, xs[t], ys[t], seen, ok);
         checks++; if ({cm_x, cm_y} !== {X_W'(xs[t]), Y_W'(ys[t])}) begin
            failures++; $display("FAIL oob%0d_cm got=%0d,%0d exp=%0d,%0d", t, cm_x, cm_y, xs[t], ys[t]); end
         wait_rsp(lat, v, w);
         checks++; if ({lat, v, w} !== {32'sd1, 4'b0010, 1'b0}) begin
            failures++; $display("FAIL oob%0d_rsp got=%0d,%b,%b exp=1,0010,0", t, lat, v, w); end
         @(negedge clk);
      end
   endtask

   task automatic test_boundary;
      logic [NR-1:0] seen, v;
      int ok, lat;
      logic w;
      issue(1, 1279, 799, seen, ok);
      checks++; if (seen !== 4'b0010) begin failures++; $display("FAIL edge_grant got=%b exp=0010", seen); end
      wait_rsp(lat, v, w);
      checks++; if ({lat, v, w} !== {32'sd3, 4'b0010, 1'b1}) begin
         failures++; $display("FAIL edge_rsp got=%0d,%b,%b exp=3,0010,1", lat, v, w); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      logic [NR-1:0] seen, v, any_rsp;
      int ok, lat;
      logic w;
      issue(2, 64, 64, seen, ok);
      checks++; if ({seen, busy} !== {4'b0100, 1'b1}) begin failures++; $display("FAIL mid_grant got=%b,%b exp=0100,1", seen, busy); end
      rst_n = 1'b0;
      #1;
      checks++; if ({req_ready, rsp_valid, busy, rsp_walkable, cm_x, cm_y} !== '0) begin
         failures++; $display("FAIL mid_reset_outputs got=%b,%b,%b,%b,%0d,%0d exp=all0", req_ready, rsp_valid, busy, rsp_walkable, cm_x, cm_y); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      any_rsp = '0;
      repeat (5) begin
         @(negedge clk);
         any_rsp = any_rsp | rsp_valid;
      end
      checks++; if (any_rsp !== 4'b0000) begin failures++; $display("FAIL mid_no_rsp got=%b exp=0000", any_rsp); end
      req_x[1*X_W +: X_W] = X_W'(64);
      req_y[1*Y_W +: Y_W] = Y_W'(64);
      req_x[3*X_W +: X_W] = X_W'(64);
      req_y[3*Y_W +: Y_W] = Y_W'(64);
      req_valid = 4'b1010;
      #1;
      checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL mid_fresh_grant got=%b exp=0010", req_ready); end
      @(negedge clk);
      req_valid = '0;
      wait_rsp(lat, v, w);
      checks++; if ({lat, v} !== {32'sd3, 4'b0010}) begin failures++; $display("FAIL mid_fresh_rsp got=%0d,%b exp=3,0010", lat, v); end
      @(negedge clk);
   endtask

`ifdef COLLISION_ARB_STATS_EN
   task automatic test_stats;
      int xs [4] = '{64, 480, 100, 1300};
      int ys [4] = '{64, 192, 100, 5};
      logic [NR-1:0] seen, v;
      int ok, lat;
      logic w;
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
      checks++; if ({stat_lookups, stat_blocked} !== 32'h0) begin
         failures++; $display("FAIL stat_clr0 got=%0d,%0d exp=0,0", stat_lookups, stat_blocked); end
      for (int t = 0; t < 4; t++) begin
         issue(0, xs[t], ys[t], seen, ok);
         wait_rsp(lat, v, w);
         @(negedge clk);
      end
      checks++; if ({stat_lookups, stat_blocked} !== {16'd3, 16'd2}) begin
         failures++; $display("FAIL stat_counts got=%0d,%0d exp=3,2", stat_lookups, stat_blocked); end
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
      checks++; if ({stat_lookups, stat_blocked} !== 32'h0) begin
         failures++; $display("FAIL stat_clr1 got=%0d,%0d exp=0,0", stat_lookups, stat_blocked); end
      force dut.stat_blocked = 16'hFFFF;
      #1;
      release dut.stat_blocked;
      issue(0, 1300, 5, seen, ok);
      wait_rsp(lat, v, w);
      @(negedge clk);
      checks++; if ({stat_lookups, stat_blocked} !== {16'd0, 16'hFFFF}) begin
         failures++; $display("FAIL stat_saturate got=%0h,%0h exp=0,ffff", stat_lookups, stat_blocked); end
   endtask
`endif

   initial begin
`ifdef COLLISION_ARB_STATS_EN
      stat_clr = 1'b0;
`endif
      @(negedge clk);
      test_reset();
      test_lookup(480, 192, 1'b0, "blocked");
      test_lookup(64, 64, 1'b1, "walkable");
      test_round_robin();
      test_out_of_bounds();
      test_boundary();
      test_reset_mid();
`ifdef COLLISION_ARB_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
